// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the memory dump transmitter and, later, the loader's RX side.
package mem_dump_tx_pkg;

  localparam int ADR_W      = 21;
  localparam int FRAME_BITS = 10;

  typedef logic [ADR_W-1:0] adr_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    WAIT_TX,
    SUM,
    DONE
  } state_t;

  function automatic adr_t adr_inc(input adr_t a);
    return a + adr_t'(1);
  endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// Host request, external memory bus and UART output of the dump engine.
interface mem_dump_tx_if;
  import mem_dump_tx_pkg::*;

  logic       start;
  adr_t       start_adr;
  adr_t       end_adr;
  adr_t       adr;
  logic       read;
  logic [7:0] din;
  logic       hold;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  modport master (
    input  start, start_adr, end_adr, din, hold,
    output adr, read, tx, busy, done, checksum
  );

  modport slave (
    output start, start_adr, end_adr, din, hold,
    input  adr, read, tx, busy, done, checksum
  );

endinterface

// File: rtl/mem_dump_tx_uart.sv
// 8N1 UART transmitter: one load pulse while ready sends start, 8 data bits LSB first, stop.
module uart_tx_8n1
  import mem_dump_tx_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [8:0]       shift_reg;

  // shift_reg holds the remaining data bits with the stop bit on top.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx          <= 1'b1;
      ready       <= 1'b1;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '1;
    end else if (ready) begin
      if (load) begin
        tx          <= 1'b0;
        ready       <= 1'b0;
        shift_reg   <= {1'b1, data};
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
      end
    end else if (div_cnt_reg != DIV_LAST) begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end else begin
      div_cnt_reg <= '0;
      if (bit_cnt_reg == BIT_LAST) begin
        ready <= 1'b1;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
        tx          <= shift_reg[0];
        shift_reg   <= {1'b1, shift_reg[8:1]};
      end
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Reads an inclusive, wrapping address range from the external bus and streams it over UART,
// optionally followed by an 8-bit additive checksum.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int CLK_DIV   = 104,
  parameter int READ_WAIT = 2,
  parameter int SEND_SUM  = 1
) (
  input logic          clk,
  input logic          n_reset,
  mem_dump_tx_if.master bus
);

  localparam int            RW_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [RW_W-1:0] RD_LAST = RW_W'(READ_WAIT - 1);

  state_t          state_reg;
  adr_t            cur_reg;
  adr_t            last_reg;
  adr_t            adr_reg;
  logic            read_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            sum_sent_reg;
  logic [RW_W-1:0] rd_cnt_reg;
  logic [7:0]      byte_reg;
  logic [7:0]      sum_reg;

  logic            tx_ready;
  logic            load;
  logic [7:0]      load_data;

  // The load pulse is combinational so a frame starts on the edge that leaves SEND/SUM.
  assign load      = ((state_reg == SEND) || (state_reg == SUM)) && tx_ready && !bus.hold;
  assign load_data = (state_reg == SUM) ? sum_reg : byte_reg;

  uart_tx_8n1 #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (load),
    .data    (load_data),
    .tx      (bus.tx),
    .ready   (tx_ready)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      cur_reg      <= '0;
      last_reg     <= '0;
      adr_reg      <= '0;
      read_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sum_sent_reg <= 1'b0;
      rd_cnt_reg   <= '0;
      byte_reg     <= '0;
      sum_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cur_reg      <= bus.start_adr;
            last_reg     <= bus.end_adr;
            adr_reg      <= bus.start_adr;
            read_reg     <= 1'b1;
            rd_cnt_reg   <= '0;
            sum_reg      <= '0;
            sum_sent_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= READ;
          end
        end
        READ: begin
          if (rd_cnt_reg == RD_LAST) begin
            byte_reg  <= bus.din;
            read_reg  <= 1'b0;
            state_reg <= SEND;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + RW_W'(1);
          end
        end
        SEND: begin
          if (load) begin
            sum_reg   <= sum_reg + byte_reg;
            state_reg <= WAIT_TX;
          end
        end
        SUM: begin
          if (load) begin
            sum_sent_reg <= 1'b1;
            state_reg    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_ready) begin
            if (sum_sent_reg) begin
              state_reg <= DONE;
            end else if (cur_reg == last_reg) begin
              state_reg <= (SEND_SUM != 0) ? SUM : DONE;
            end else begin
              cur_reg    <= adr_inc(cur_reg);
              adr_reg    <= adr_inc(cur_reg);
              read_reg   <= 1'b1;
              rd_cnt_reg <= '0;
              state_reg  <= READ;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.adr      = adr_reg;
  assign bus.read     = read_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.checksum = sum_reg;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Randomised bench for mem_dump_tx: decodes the UART stream and compares it with a range model.
module tb_mem_dump_tx;
  import mem_dump_tx_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int READ_WAIT = 2;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_dump_tx_if bus();

  mem_dump_tx #(.CLK_DIV(CLK_DIV), .READ_WAIT(READ_WAIT), .SEND_SUM(1)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: each location returns its low address byte scrambled.
  assign bus.din = bus.adr[7:0] ^ 8'hA5;

  // Monitor: UART decoder plus read-strobe and done bookkeeping, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int         start_q[$];
  adr_t       rd_adr_q[$];
  int         rd_cycles, done_cnt, bad_frames;
  bit         rx_busy = 0;
  bit         rx_ok;
  bit         read_prev = 0;
  int         rx_cnt, rx_t0;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (!n_reset) begin
      rx_busy = 0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.read && !read_prev) rd_adr_q.push_back(bus.adr);
      if (bus.read) rd_cycles++;
      if (!rx_busy) begin
        if (bus.tx == 1'b0) begin
          rx_busy = 1; rx_cnt = 0; rx_t0 = cyc; rx_ok = 1;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 2 && bus.tx !== 1'b0) rx_ok = 0;
        if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % CLK_DIV) == 2) rx_byte = {bus.tx, rx_byte[7:1]};
        if (rx_cnt == 38) begin
          if (bus.tx !== 1'b1 || !rx_ok) bad_frames++;
          rx_q.push_back(rx_byte);
          start_q.push_back(rx_t0);
          rx_busy = 0;
        end
      end
    end
    read_prev = bus.read;
  end

  // Reference model: expected data bytes, checksum and address order for an inclusive range.
  logic [7:0] exp_q[$];
  adr_t       exp_adr_q[$];
  logic [7:0] exp_sum;
  bit         to_flag;

  function automatic void build_exp(input adr_t s, input adr_t e);
    int n;
    adr_t a;
    logic [7:0] sum;
    exp_q.delete(); exp_adr_q.delete(); sum = 8'h00;
    n = int'(adr_t'(e - s)) + 1;
    for (int i = 0; i < n; i++) begin
      a = adr_t'(s + adr_t'(i));
      exp_adr_q.push_back(a);
      exp_q.push_back(a[7:0] ^ 8'hA5);
      sum = sum + (a[7:0] ^ 8'hA5);
    end
    exp_sum = sum;
    exp_q.push_back(sum);
  endfunction

  task automatic clear_mon();
    rx_q.delete(); start_q.delete(); rd_adr_q.delete();
    rd_cycles = 0; done_cnt = 0; bad_frames = 0;
  endtask

  // Issues one accepted start and waits (bounded) for done; called aligned at posedge+1.
  task automatic do_dump(input adr_t s, input adr_t e, output bit to);
    clear_mon();
    build_exp(s, e);
    bus.start_adr = s; bus.end_adr = e; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    to = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.done) begin to = 0; break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #22;
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", bus.tx); end
    n_checks++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b want 0", bus.read); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.adr !== 21'h0) begin n_fail++; $display("FAIL reset_adr got %h want 0", bus.adr); end
    n_checks++; if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum got %h want 00", bus.checksum); end
    @(negedge clk); n_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.busy); end
  endtask

  task automatic test_basic();
    bit ok;
    do_dump(21'h00010, 21'h00012, to_flag);
    n_checks++; if (to_flag) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_bytes got %0d bytes last %h want %0d last %h", rx_q.size(), rx_q[$], exp_q.size(), exp_q[$]); end
    n_checks++; if (bus.checksum !== exp_sum) begin n_fail++; $display("FAIL basic_checksum got %h want %h", bus.checksum, exp_sum); end
    // Data frames start READ_WAIT+1+10*CLK_DIV+1 apart; the checksum frame follows 2 cycles after the last stop bit.
    n_checks++; if (start_q.size() != 4 || start_q[1] - start_q[0] != 44 || start_q[2] - start_q[1] != 44 || start_q[3] - start_q[2] != 42) begin
      n_fail++; $display("FAIL basic_spacing got %0d frames want 4 frames spaced 44,44,42", start_q.size()); end
    n_checks++; if (done_cnt != 1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got pulses=%0d busy=%b want 1 and 0", done_cnt, bus.busy); end
    n_checks++; if (rd_cycles != READ_WAIT * 3 || bad_frames != 0) begin n_fail++; $display("FAIL basic_read got read_cycles=%0d bad_frames=%0d want %0d and 0", rd_cycles, bad_frames, READ_WAIT * 3); end
  endtask

  task automatic test_single();
    bit ok;
    do_dump(21'h1FFFFF, 21'h1FFFFF, to_flag);
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    n_checks++; if (to_flag || !ok) begin n_fail++; $display("FAIL single_bytes got %0d bytes first %h want %0d first %h", rx_q.size(), rx_q[0], exp_q.size(), exp_q[0]); end
    n_checks++; if (bus.adr !== 21'h1FFFFF) begin n_fail++; $display("FAIL single_adr got %h want 1fffff", bus.adr); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_dump(21'h1FFFFE, 21'h000001, to_flag);
    ok = (rd_adr_q.size() == exp_adr_q.size());
    foreach (exp_adr_q[i]) if (ok && rd_adr_q[i] !== exp_adr_q[i]) ok = 0;
    n_checks++; if (to_flag || !ok) begin n_fail++; $display("FAIL wrap_adr got %0d reads last %h want %0d last %h", rd_adr_q.size(), rd_adr_q[$], exp_adr_q.size(), exp_adr_q[$]); end
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_bytes got %0d bytes last %h want %0d last %h", rx_q.size(), rx_q[$], exp_q.size(), exp_q[$]); end
  endtask

  task automatic test_random();
    bit ok;
    adr_t s, e;
    for (int it = 0; it < 5; it++) begin
      s = (it % 2 == 0) ? adr_t'($urandom) : adr_t'(21'h1FFFFF - adr_t'($urandom_range(0, 3)));
      e = adr_t'(s + adr_t'($urandom_range(0, 5)));
      do_dump(s, e, to_flag);
      ok = (rx_q.size() == exp_q.size()) && (rd_adr_q.size() == exp_adr_q.size());
      foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
      foreach (exp_adr_q[i]) if (ok && rd_adr_q[i] !== exp_adr_q[i]) ok = 0;
      n_checks++; if (to_flag || !ok || bad_frames != 0) begin n_fail++; $display("FAIL random_%0d got %0d bytes %0d reads want %0d bytes %0d reads (start %h end %h)", it, rx_q.size(), rd_adr_q.size(), exp_q.size(), exp_adr_q.size(), s, e); end
      n_checks++; if (bus.checksum !== exp_sum || done_cnt != 1) begin n_fail++; $display("FAIL random_sum_%0d got %h pulses=%0d want %h pulses=1", it, bus.checksum, done_cnt, exp_sum); end
    end
  endtask

  task automatic test_hold();
    bit ok;
    int rel_cyc = 0;
    bit seen = 0;
    adr_t s = adr_t'($urandom);
    fork
      do_dump(s, adr_t'(s + adr_t'(2)), to_flag);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (bus.tx == 1'b0) begin seen = 1; break; end
        end
        repeat (10) @(posedge clk);
        #1 bus.hold = 1'b1;
        repeat (100) @(posedge clk);
        #1 bus.hold = 1'b0;
        rel_cyc = cyc;
      end
    join
    n_checks++; if (!seen) begin n_fail++; $display("FAIL hold_first_frame got no frame want frame"); end
    ok = (rx_q.size() == exp_q.size()) && (rd_adr_q.size() == exp_adr_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    foreach (exp_adr_q[i]) if (ok && rd_adr_q[i] !== exp_adr_q[i]) ok = 0;
    n_checks++; if (to_flag || !ok) begin n_fail++; $display("FAIL hold_bytes got %0d bytes %0d reads want %0d bytes %0d reads", rx_q.size(), rd_adr_q.size(), exp_q.size(), exp_adr_q.size()); end
    n_checks++; if (start_q.size() < 2 || start_q[1] <= rel_cyc) begin n_fail++; $display("FAIL hold_gap got second frame at %0d want after %0d", (start_q.size() > 1) ? start_q[1] : -1, rel_cyc); end
  endtask

  task automatic test_busy_restart();
    bit ok;
    adr_t s = adr_t'($urandom);
    fork
      do_dump(s, adr_t'(s + adr_t'(2)), to_flag);
      begin
        repeat (60) @(posedge clk);
        #1 bus.start_adr = adr_t'($urandom); bus.end_adr = adr_t'($urandom); bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
      end
    join
    ok = (rx_q.size() == exp_q.size()) && (rd_adr_q.size() == exp_adr_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    foreach (exp_adr_q[i]) if (ok && rd_adr_q[i] !== exp_adr_q[i]) ok = 0;
    n_checks++; if (to_flag || !ok || done_cnt != 1) begin n_fail++; $display("FAIL restart_ignored got %0d bytes %0d reads %0d pulses want %0d bytes %0d reads 1 pulse", rx_q.size(), rd_adr_q.size(), done_cnt, exp_q.size(), exp_adr_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit reached = 0;
    adr_t s = adr_t'($urandom);
    clear_mon();
    bus.start_adr = s; bus.end_adr = adr_t'(s + adr_t'(3)); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_q.size() == 1 && bus.tx == 1'b0) begin reached = 1; break; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL reset_mid_second_frame got none want frame"); end
    repeat (18) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    n_checks++; if (bus.tx !== 1'b1 || bus.read !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async got tx=%b read=%b busy=%b want 1 0 0", bus.tx, bus.read, bus.busy); end
    repeat (2) @(posedge clk);
    #2 n_reset = 1'b1;
    @(posedge clk); #1;
    s = adr_t'($urandom);
    do_dump(s, adr_t'(s + adr_t'(1)), to_flag);
    ok = (rx_q.size() == exp_q.size()) && (rd_adr_q.size() == exp_adr_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 0;
    foreach (exp_adr_q[i]) if (ok && rd_adr_q[i] !== exp_adr_q[i]) ok = 0;
    n_checks++; if (to_flag || !ok || bad_frames != 0) begin n_fail++; $display("FAIL reset_mid_clean got %0d bytes %0d reads want %0d bytes %0d reads", rx_q.size(), rd_adr_q.size(), exp_q.size(), exp_adr_q.size()); end
  endtask

  initial begin
    bus.start = 1'b0; bus.start_adr = '0; bus.end_adr = '0; bus.hold = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_random();
    test_hold();
    test_busy_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
